// File: rtl/udp_02467_pkg.sv
// Shared types and helpers for the UDP 02467 registered logic leaf.
// Holds the default truth table and the minterm lookup used by the core.
package udp_02467_pkg;

  localparam logic [7:0] DEFAULT_MINTERM_MASK = 8'b1101_0101;

  // Registered result bundle, ordered so {e,f,g} maps directly onto a 3-bit value.
  typedef struct packed {
    logic e;
    logic f;
    logic g;
  } efg_t;

  // Bit idx of the mask is the function value for minterm idx.
  function automatic logic minterm_lookup(input logic [7:0] mask, input logic [2:0] idx);
    return mask[idx];
  endfunction

endpackage

// File: rtl/udp_02467_if.sv
// Signal bundle for the UDP 02467 leaf: four function inputs, three results.
// master drives a..d and observes e..g; slave is the circuit side.
interface udp_02467_if;
  logic a;
  logic b;
  logic c;
  logic d;
  logic e;
  logic f;
  logic g;

  modport master (
    output a, b, c, d,
    input  e, f, g
  );

  modport slave (
    input  a, b, c, d,
    output e, f, g
  );
endinterface

// File: rtl/udp_02467_comb.sv
// Purely combinational E/F/G generator: E from the minterm mask over {a,b,c},
// F qualifies E with d, G is E xor d.
module udp_02467_comb
  import udp_02467_pkg::*;
#(
  parameter logic [7:0] MINTERM_MASK = DEFAULT_MINTERM_MASK
) (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output efg_t efg
);

  logic e_n;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    efg   = '0;
    e_n   = minterm_lookup(MINTERM_MASK, {a, b, c});
    efg.e = e_n;
    efg.f = e_n & d;
    efg.g = e_n ^ d;
  end

endmodule

// File: rtl/udp_02467_circuit.sv
// Registered UDP 02467 leaf: combinational core followed by one output register,
// giving a fresh {e,f,g} every cycle with exactly one cycle of latency.
module udp_02467_circuit
  import udp_02467_pkg::*;
#(
  parameter logic [7:0] MINTERM_MASK = DEFAULT_MINTERM_MASK,
  parameter logic [2:0] RESET_VAL    = 3'b000
) (
  input  logic          clk,
  input  logic          rst_n,
  udp_02467_if.slave    bus
);

  efg_t efg_n;
  efg_t efg_d;
  efg_t efg_q;

  udp_02467_comb #(
    .MINTERM_MASK (MINTERM_MASK)
  ) u_comb (
    .a   (bus.a),
    .b   (bus.b),
    .c   (bus.c),
    .d   (bus.d),
    .efg (efg_n)
  );

  // No enable or handshake: the register always takes the new result.
  always_comb begin
    efg_d = efg_n;
  end

  // Async clear drops any result captured before reset asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      efg_q <= efg_t'(RESET_VAL);
    end else begin
      efg_q <= efg_d;
    end
  end

  assign bus.e = efg_q.e;
  assign bus.f = efg_q.f;
  assign bus.g = efg_q.g;

endmodule

// File: tb/tb_udp_02467_circuit.sv
// Directed self-checking bench for udp_02467_circuit: default-mask and
// overridden-mask instances share the same stimulus.
module tb_udp_02467_circuit;

  logic clk;
  logic rst_n;
  logic a, b, c, d;

  int checks = 0;
  int errors = 0;

  udp_02467_if bus1 ();
  udp_02467_if bus2 ();

  assign bus1.a = a;
  assign bus1.b = b;
  assign bus1.c = c;
  assign bus1.d = d;
  assign bus2.a = a;
  assign bus2.b = b;
  assign bus2.c = c;
  assign bus2.d = d;

  udp_02467_circuit dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  udp_02467_circuit #(
    .MINTERM_MASK (8'b0000_0001)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] efg1();
    return {bus1.e, bus1.f, bus1.g};
  endfunction

  function automatic logic [2:0] efg2();
    return {bus2.e, bus2.f, bus2.g};
  endfunction

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] abcd);
    {a, b, c, d} = abcd;
  endtask

  // Reference model written from the truth table rather than a mask index.
  function automatic logic [2:0] model(input logic [3:0] abcd, input bit alt_mask);
    logic [2:0] idx;
    logic       ev;
    logic       dv;
    idx = abcd[3:1];
    dv  = abcd[0];
    if (alt_mask) ev = (idx == 3'd0);
    else          ev = (idx == 3'd0) || (idx == 3'd2) || (idx == 3'd4) ||
                       (idx == 3'd6) || (idx == 3'd7);
    return {ev, ev & dv, ev ^ dv};
  endfunction

  // Called just after a rising edge: drive, confirm hold at mid-cycle, confirm update after edge.
  task automatic apply(input string tag, input logic [3:0] abcd, input logic [2:0] exp1,
                       input logic [2:0] exp2);
    logic [2:0] prev1;
    logic [2:0] prev2;
    prev1 = efg1();
    prev2 = efg2();
    drive(abcd);
    @(negedge clk);
    check({tag, "_hold"}, efg1(), prev1);
    check({tag, "_hold_alt"}, efg2(), prev2);
    @(posedge clk);
    #1;
    check(tag, efg1(), exp1);
    check({tag, "_alt"}, efg2(), exp2);
  endtask

  typedef struct {
    logic [3:0] abcd;
    logic [2:0] efg;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{4'b1100, 3'b101};
    vecs[1] = '{4'b1110, 3'b101};
    vecs[2] = '{4'b1111, 3'b110};
    vecs[3] = '{4'b1001, 3'b110};
    vecs[4] = '{4'b1010, 3'b000};
    vecs[5] = '{4'b0100, 3'b101};
    vecs[6] = '{4'b0111, 3'b001};
    vecs[7] = '{4'b0001, 3'b110};
    vecs[8] = '{4'b0010, 3'b000};

    // Reset held with all inputs high across several edges.
    rst_n = 1'b0;
    drive(4'b1111);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", efg1(), 3'b000);
    check("reset_hold_alt", efg2(), 3'b000);

    // Release mid-cycle with 0100 stable: still 000 until the next edge.
    drive(4'b0100);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_pre_edge", efg1(), 3'b000);
    @(posedge clk);
    #1;
    check("release_first_edge", efg1(), 3'b101);
    check("release_first_edge_alt", efg2(), 3'b000);

    // Directed sequence.
    foreach (vecs[i])
      apply($sformatf("seq_%b", vecs[i].abcd), vecs[i].abcd, vecs[i].efg,
            model(vecs[i].abcd, 1'b1));

    // Asynchronous reset mid-cycle after outputs go nonzero.
    apply("pre_async", 4'b1111, 3'b110, 3'b001);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_clear", efg1(), 3'b000);
    check("async_clear_alt", efg2(), 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_async_release", efg1(), 3'b110);

    // Exhaustive sweep against the model for both masks.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      apply($sformatf("sweep_%b", v), v, model(v, 1'b0), model(v, 1'b1));
    end

    // Mid-cycle change and glitch on c are invisible until the edge.
    apply("glitch_setup", 4'b0001, 3'b110, 3'b110);
    #1;
    drive(4'b0010);
    #1 c = 1'b0;
    #1 c = 1'b1;
    @(negedge clk);
    check("glitch_mid_hold", efg1(), 3'b110);
    #1 c = 1'b0;
    #1 c = 1'b1;
    @(posedge clk);
    #1;
    check("glitch_edge", efg1(), 3'b000);
    check("glitch_edge_alt", efg2(), 3'b000);

    // Overridden mask spot checks.
    apply("alt_0001", 4'b0001, 3'b110, 3'b110);
    apply("alt_1001", 4'b1001, 3'b110, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
